penc_crc_24c_attach: RTL and testbench



---
 rtl/penc_pkg.sv | 22 ++
 rtl/penc_crc_24c_step.sv | 14 +
 rtl/penc_crc_24c_attach.sv | 119 +++++++++++
 tb/tb_penc_crc_24c_attach.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/penc_pkg.sv
// Shared CRC-24C definitions for the polar encoder/decoder chain.
// Both the transmit attach and the receive checker step through crc24c_step.
package penc_pkg;

  localparam int                 CRC24_W     = 24;
  localparam logic [CRC24_W-1:0] CRC24C_MASK = 24'hE88D4D;

  typedef enum logic {
    PAYLOAD = 1'b0,
    PARITY  = 1'b1
  } penc_state_e;

  // Reflected, right-shifting single-bit CRC update.
  function automatic logic [CRC24_W-1:0] crc24c_step(
    input logic [CRC24_W-1:0] crc,
    input logic               d,
    input logic [CRC24_W-1:0] mask
  );
    crc24c_step = (crc >> 1) ^ ((crc[0] ^ d) ? mask : '0);
  endfunction

endpackage

// File: rtl/penc_crc_24c_step.sv
// Combinational one-bit CRC-24C step, a thin wrapper over the shared function.
module penc_crc_24c_step
  import penc_pkg::*;
#(
  parameter logic [CRC24_W-1:0] MASK = CRC24C_MASK
) (
  input  logic [0:0]         dat_in,
  input  logic [CRC24_W-1:0] crc_in,
  output logic [CRC24_W-1:0] crc_out
);

  assign crc_out = crc24c_step(crc_in, dat_in[0], MASK);

endmodule

// File: rtl/penc_crc_24c_attach.sv
// Bit-serial CRC-24C attach: forwards payload bits, then appends the 24 parity
// bits LSB first through a single output register stage.
module penc_crc_24c_attach
  import penc_pkg::*;
#(
  parameter logic [CRC24_W-1:0] CRC_INIT = 24'h000000,
  parameter logic [CRC24_W-1:0] CRC_MASK = 24'hE88D4D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_data,
  output logic               m_last,
  output logic [CRC24_W-1:0] crc_word,
  output logic               crc_vld
);

  penc_state_e        state_q, state_d;
  logic [CRC24_W-1:0] c_q, c_d;
  logic [4:0]         pcnt_q, pcnt_d;
  logic               m_valid_q, m_valid_d;
  logic               m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic [CRC24_W-1:0] crc_word_q, crc_word_d;
  logic               crc_vld_q, crc_vld_d;
  logic [CRC24_W-1:0] crc_step;
  logic               free;

  penc_crc_24c_step #(
    .MASK(CRC_MASK)
  ) u_step (
    .dat_in (s_data),
    .crc_in (c_q),
    .crc_out(crc_step)
  );

  // The output register can take a new bit when empty or draining this cycle.
  assign free    = !m_valid_q || m_ready;
  assign s_ready = (state_q == PAYLOAD) && free;

  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    pcnt_d     = pcnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    crc_word_d = crc_word_q;
    crc_vld_d  = 1'b0;

    if (free) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      case (state_q)
        PAYLOAD: begin
          if (s_valid) begin
            m_data_d  = s_data;
            m_valid_d = 1'b1;
            c_d       = crc_step;
            if (s_last) begin
              crc_word_d = crc_step;
              crc_vld_d  = 1'b1;
              pcnt_d     = '0;
              state_d    = PARITY;
            end
          end
        end
        PARITY: begin
          // c_q holds the finished CRC; shifting it out emits crc_word LSB first.
          m_data_d  = c_q[0];
          m_valid_d = 1'b1;
          c_d       = c_q >> 1;
          pcnt_d    = pcnt_q + 5'd1;
          if (pcnt_q == 5'd23) begin
            m_last_d = 1'b1;
            c_d      = CRC_INIT;
            pcnt_d   = '0;
            state_d  = PAYLOAD;
          end
        end
        default: state_d = PAYLOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PAYLOAD;
      c_q        <= CRC_INIT;
      pcnt_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 1'b0;
      m_last_q   <= 1'b0;
      crc_word_q <= '0;
      crc_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      pcnt_q     <= pcnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      crc_word_q <= crc_word_d;
      crc_vld_q  <= crc_vld_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign crc_word = crc_word_q;
  assign crc_vld  = crc_vld_q;

endmodule

// File: tb/tb_penc_crc_24c_attach.sv
// Scoreboard bench for the CRC-24C attach block: expected output beats are
// queued on input accept and popped by a monitor on every output transfer.
module tb_penc_crc_24c_attach;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_data = 1'b0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_data;
  logic        m_last;
  logic [23:0] crc_word;
  logic        crc_vld;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [1:0]  exp_q[$];
  logic [23:0] crc_exp_q[$];
  logic        out_log[$];
  int          beat_cyc[$];
  logic [23:0] mc = 24'h0;
  logic [23:0] last_crc = 24'h0;
  int          crc_cnt = 0;
  logic        hold_pending = 1'b0;
  logic        hold_d, hold_l;

  penc_crc_24c_attach #(
    .CRC_INIT(24'h000000),
    .CRC_MASK(24'hE88D4D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .crc_word(crc_word),
    .crc_vld (crc_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] mstep(input logic [23:0] c, input logic d);
    logic [23:0] r;
    r = c >> 1;
    if (c[0] ^ d) r = r ^ 24'hE88D4D;
    return r;
  endfunction

  // Model the accepted bit: forward it, and on last append the parity beats.
  task automatic push_bit(input logic d, input logic last);
    exp_q.push_back({d, 1'b0});
    mc = mstep(mc, d);
    if (last) begin
      crc_exp_q.push_back(mc);
      for (int i = 0; i < 24; i++) exp_q.push_back({mc[i], (i == 23)});
      mc = 24'h0;
    end
  endtask

  // Monitor: stall stability, output beats, and crc_vld pulses.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l) begin
          errors++;
          $display("FAIL stall_stable: got v=%b d=%b l=%b want v=1 d=%b l=%b",
                   m_valid, m_data, m_last, hold_d, hold_l);
        end
      end
      hold_pending = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
      if (m_valid && m_ready) begin
        logic [1:0] e;
        out_log.push_back(m_data);
        beat_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat: got unexpected beat d=%b l=%b, want none", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_data, m_last} !== e) begin
            errors++;
            $display("FAIL out_beat: got d=%b l=%b want d=%b l=%b", m_data, m_last, e[1], e[0]);
          end
        end
      end
      if (crc_vld) begin
        crc_cnt++;
        last_crc = crc_word;
        checks++;
        if (crc_exp_q.size() == 0) begin
          errors++;
          $display("FAIL crc_vld: got unexpected pulse word=%h, want none", crc_word);
        end else begin
          logic [23:0] ec;
          ec = crc_exp_q.pop_front();
          if (crc_word !== ec) begin
            errors++;
            $display("FAIL crc_word: got %h want %h", crc_word, ec);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic d, input logic last, input bit rnd);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (s_ready) begin
        push_bit(d, last);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no s_ready, want accept");
    end
  endtask

  task automatic drain(input bit rnd);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      if (exp_q.size() == 0 && !m_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, want 0", exp_q.size());
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks += 6;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    if (m_data !== 1'b0) begin errors++; $display("FAIL rst_m_data: got %b want 0", m_data); end
    if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    if (crc_word !== 24'h0) begin errors++; $display("FAIL rst_crc_word: got %h want 0", crc_word); end
    if (crc_vld !== 1'b0) begin errors++; $display("FAIL rst_crc_vld: got %b want 0", crc_vld); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    m_ready = 1'b1;
  endtask

  task automatic test_single_one();
    int c0;
    c0 = crc_cnt;
    out_log.delete();
    send_bit(1'b1, 1'b1, 1'b0);
    drain(1'b0);
    checks += 3;
    if (crc_cnt - c0 != 1) begin errors++; $display("FAIL single_vld_cnt: got %0d want 1", crc_cnt - c0); end
    if (last_crc !== 24'hE88D4D) begin errors++; $display("FAIL single_crc: got %h want e88d4d", last_crc); end
    if (out_log.size() != 25) begin errors++; $display("FAIL single_beats: got %0d want 25", out_log.size()); end
  endtask

  task automatic test_zeros();
    out_log.delete();
    for (int i = 0; i < 8; i++) send_bit(1'b0, (i == 7), 1'b0);
    drain(1'b0);
    checks += 2;
    if (last_crc !== 24'h0) begin errors++; $display("FAIL zeros_crc: got %h want 0", last_crc); end
    if (out_log.size() != 32) begin errors++; $display("FAIL zeros_beats: got %0d want 32", out_log.size()); end
  endtask

  task automatic test_random();
    logic [23:0] r;
    out_log.delete();
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)), (i == 39), 1'b1);
    drain(1'b1);
    r = 24'h0;
    foreach (out_log[i]) r = mstep(r, out_log[i]);
    checks += 2;
    if (out_log.size() != 64) begin errors++; $display("FAIL rand_beats: got %0d want 64", out_log.size()); end
    if (r !== 24'h0) begin errors++; $display("FAIL rand_residue: got %h want 0", r); end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = crc_cnt;
    out_log.delete();
    beat_cyc.delete();
    for (int i = 0; i < 16; i++) send_bit(1'(i % 3 == 0), (i == 15), 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    drain(1'b0);
    checks += 4;
    if (out_log.size() != 65) begin
      errors++; $display("FAIL b2b_beats: got %0d want 65", out_log.size());
    end else if (beat_cyc[64] - beat_cyc[0] != 64) begin
      errors++; $display("FAIL b2b_gapless: got span %0d want 64", beat_cyc[64] - beat_cyc[0]);
    end
    if (crc_cnt - c0 != 2) begin errors++; $display("FAIL b2b_vld_cnt: got %0d want 2", crc_cnt - c0); end
    if (last_crc !== 24'hE88D4D) begin errors++; $display("FAIL b2b_crc2: got %h want e88d4d", last_crc); end
    if (out_log.size() == 65 && out_log[40] !== 1'b1) begin
      errors++; $display("FAIL b2b_second_first: got %b want 1", out_log[40]);
    end
  endtask

  task automatic test_reset_parity();
    bit hit;
    int c0;
    out_log.delete();
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1), (i == 3), 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      #3;
      if (out_log.size() >= 14) hit = 1'b1;
    end
    c0 = crc_cnt;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    crc_exp_q.delete();
    mc = 24'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks += 4;
    if (!hit) begin errors++; $display("FAIL rstp_reach: got %0d beats want 14", out_log.size()); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rstp_m_valid: got %b want 0", m_valid); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rstp_s_ready: got %b want 1", s_ready); end
    if (crc_vld !== 1'b0) begin errors++; $display("FAIL rstp_crc_vld: got %b want 0", crc_vld); end
    send_bit(1'b1, 1'b1, 1'b0);
    drain(1'b0);
    checks += 2;
    if (crc_cnt - c0 != 1) begin errors++; $display("FAIL rstp_vld_cnt: got %0d want 1", crc_cnt - c0); end
    if (last_crc !== 24'hE88D4D) begin errors++; $display("FAIL rstp_crc: got %h want e88d4d", last_crc); end
  endtask

  task automatic test_stall();
    int acc;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 1'b1;
      s_last  = 1'b0;
      m_ready = 1'b0;
      #1;
      if (i > 0) begin
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_s_ready: got %b want 0", s_ready); end
      end
      if (s_valid && s_ready) begin
        push_bit(1'b1, 1'b0);
        acc++;
      end
    end
    checks++;
    if (acc != 1) begin errors++; $display("FAIL stall_accepts: got %0d want 1", acc); end
    send_bit(1'b0, 1'b1, 1'b0);
    drain(1'b0);
  endtask

  initial begin
    test_reset();
    test_single_one();
    test_zeros();
    test_random();
    test_back_to_back();
    test_reset_parity();
    test_stall();
    checks++;
    if (exp_q.size() != 0 || crc_exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d beats %0d crcs, want 0", exp_q.size(), crc_exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
